hs_npu_systolic_ws: RTL and testbench

//  Weight-stationary ROWS x COLS systolic MAC tile for the NPU datapath. Weights are

---
 rtl/hs_npu_systolic_ws.sv | 209 ++++++++++++++++++++
 tb/tb_hs_npu_systolic_ws.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_npu_systolic_ws.sv
// Weight-stationary ROWS x COLS systolic MAC tile: weights preloaded per row,
// activation vectors streamed with skew/de-skew and a global stall enable.
module hs_npu_systolic_ws #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    w_valid_in,
  output logic                    w_ready_out,
  input  logic [COLS*DATA_W-1:0]  w_row_in,
  input  logic                    act_valid_in,
  output logic                    act_ready_out,
  input  logic [ROWS*DATA_W-1:0]  act_in,
  input  logic [COLS*ACC_W-1:0]   bias_in,
  input  logic                    flush_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic                    busy_out
);

  localparam int L  = ROWS + COLS;
  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE, S_LOAD, S_COMP, S_DRAIN
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_w_ready;
  logic [L:0]         r_v;
  logic [COLS*ACC_W-1:0] r_out;
  logic               w_adv;
  logic               w_acc;
  logic               w_wacc;

  logic signed [DATA_W-1:0] r_w   [ROWS][COLS];
  logic signed [DATA_W-1:0] w_ah  [ROWS][COLS];
  logic signed [ACC_W-1:0]  w_pv  [ROWS][COLS];
  logic signed [DATA_W-1:0] w_arow [ROWS];
  logic signed [ACC_W-1:0]  w_bcol [COLS];
  logic signed [ACC_W-1:0]  w_dsk  [COLS];

  function automatic logic signed [ACC_W-1:0] f_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (SATURATE && (s[ACC_W] != s[ACC_W-1]))
      f_add = s[ACC_W] ? MINV : MAXV;
    else
      f_add = s[ACC_W-1:0];
  endfunction

  assign w_adv         = !(r_v[L] && !out_ready);
  assign act_ready_out = (r_state == S_COMP) && w_adv;
  assign w_acc         = act_valid_in && act_ready_out;
  assign w_wacc        = w_valid_in && r_w_ready;
  assign w_ready_out   = r_w_ready;
  assign out_valid     = r_v[L];
  assign out_data      = r_out;
  assign busy_out      = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_w_ready <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_LOAD: begin
          r_w_ready <= 1'b1;
          if (w_wacc) begin
            if (r_cnt == CW'(ROWS-1)) begin
              r_cnt     <= '0;
              r_state   <= S_COMP;
              r_w_ready <= 1'b0;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_COMP: begin
          r_w_ready <= 1'b0;
          if (flush_in) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (r_v == '0) begin
            r_state   <= S_IDLE;
            r_w_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < ROWS; k++)
        for (int c = 0; c < COLS; c++)
          r_w[k][c] <= '0;
    end else if (w_wacc) begin
      for (int k = 0; k < ROWS; k++)
        if (CW'(k) == r_cnt)
          for (int c = 0; c < COLS; c++)
            r_w[k][c] <= w_row_in[c*DATA_W +: DATA_W];
    end
  end

  // r_v[L] is out_valid; it lines up with the registered output lane
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_out <= '0;
    end else if (w_adv) begin
      r_v <= {r_v[L-1:0], w_acc};
      for (int c = 0; c < COLS; c++)
        r_out[c*ACC_W +: ACC_W] <= w_dsk[c];
    end
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_ask
    logic signed [DATA_W-1:0] r_sk [gr+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k <= gr; k++) r_sk[k] <= '0;
      end else if (w_adv) begin
        r_sk[0] <= w_acc ? act_in[gr*DATA_W +: DATA_W] : '0;
        for (int k = 1; k <= gr; k++) r_sk[k] <= r_sk[k-1];
      end
    end
    assign w_arow[gr] = r_sk[gr];
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_bsk
    logic signed [ACC_W-1:0] r_sk [gc+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int k = 0; k <= gc; k++) r_sk[k] <= '0;
      end else if (w_adv) begin
        r_sk[0] <= w_acc ? bias_in[gc*ACC_W +: ACC_W] : '0;
        for (int k = 1; k <= gc; k++) r_sk[k] <= r_sk[k-1];
      end
    end
    assign w_bcol[gc] = r_sk[gc];
  end

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_pe
      logic signed [DATA_W-1:0] w_ain;
      logic signed [ACC_W-1:0]  w_pin;
      logic signed [PW-1:0]     w_prod;
      logic signed [DATA_W-1:0] r_a;
      logic signed [ACC_W-1:0]  r_p;
      if (gc == 0) begin : g_al
        assign w_ain = w_arow[gr];
      end else begin : g_ai
        assign w_ain = w_ah[gr][gc-1];
      end
      if (gr == 0) begin : g_pt
        assign w_pin = w_bcol[gc];
      end else begin : g_pi
        assign w_pin = w_pv[gr-1][gc];
      end
      assign w_prod = PW'(w_ain) * PW'(r_w[gr][gc]);
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_p <= '0;
        end else if (w_adv) begin
          r_a <= w_ain;
          r_p <= f_add(w_pin, ACC_W'(w_prod));
        end
      end
      assign w_ah[gr][gc] = r_a;
      assign w_pv[gr][gc] = r_p;
    end
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : g_dsk
    localparam int D = COLS - 1 - gc;
    if (D == 0) begin : g_n
      assign w_dsk[gc] = w_pv[ROWS-1][gc];
    end else begin : g_d
      logic signed [ACC_W-1:0] r_d [D];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < D; k++) r_d[k] <= '0;
        end else if (w_adv) begin
          r_d[0] <= w_pv[ROWS-1][gc];
          for (int k = 1; k < D; k++) r_d[k] <= r_d[k-1];
        end
      end
      assign w_dsk[gc] = r_d[D-1];
    end
  end

endmodule

// File: tb/tb_hs_npu_systolic_ws.sv
// Directed bench for hs_npu_systolic_ws (2x2 tile, wrapping and saturating
// instances side by side on shared stimulus).
module tb_hs_npu_systolic_ws;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_valid_in;
  logic [31:0] w_row_in;
  logic        act_valid_in;
  logic [31:0] act_in;
  logic [63:0] bias_in;
  logic        flush_in;
  logic        out_ready;

  logic        w_rdy0, a_rdy0, ov0, busy0;
  logic [63:0] od0;
  logic        w_rdy1, a_rdy1, ov1, busy1;
  logic [63:0] od1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hs_npu_systolic_ws #(
    .ROWS(2), .COLS(2), .DATA_W(16), .ACC_W(32), .SATURATE(1'b0)
  ) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .w_valid_in(w_valid_in), .w_ready_out(w_rdy0), .w_row_in(w_row_in),
    .act_valid_in(act_valid_in), .act_ready_out(a_rdy0),
    .act_in(act_in), .bias_in(bias_in), .flush_in(flush_in),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .busy_out(busy0)
  );

  hs_npu_systolic_ws #(
    .ROWS(2), .COLS(2), .DATA_W(16), .ACC_W(32), .SATURATE(1'b1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n),
    .w_valid_in(w_valid_in), .w_ready_out(w_rdy1), .w_row_in(w_row_in),
    .act_valid_in(act_valid_in), .act_ready_out(a_rdy1),
    .act_in(act_in), .bias_in(bias_in), .flush_in(flush_in),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .busy_out(busy1)
  );

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk16(input int a, input int b);
    return {b[15:0], a[15:0]};
  endfunction

  function automatic logic [63:0] pk32(input int a, input int b);
    return {b, a};
  endfunction

  task automatic load_w(input logic [31:0] r0, input logic [31:0] r1);
    w_valid_in = 1'b1;
    w_row_in   = r0;
    tick();
    w_row_in   = r1;
    tick();
    w_valid_in = 1'b0;
    w_row_in   = '0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy0; i++) tick();
    chk(tag, busy0, 1'b0);
    chk({tag, "_wrdy"}, w_rdy0, 1'b1);
  endtask

  initial begin
    int          sent, rcvd, nstall;
    logic        prev, acc;
    logic [63:0] held;

    rst_n = 1'b0; w_valid_in = 1'b0; w_row_in = '0;
    act_valid_in = 1'b0; act_in = '0; bias_in = '0;
    flush_in = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_ov", ov0, 1'b0);
    chk("rst_od", od0, 64'd0);
    chk("rst_wrdy", w_rdy0, 1'b0);
    chk("rst_ardy", a_rdy0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("idle_wrdy", w_rdy0, 1'b1);
    chk("idle_busy", busy0, 1'b0);

    // W = [[1,2],[3,4]], act = [5,6]
    load_w(pk16(1, 2), pk16(3, 4));
    chk("comp_busy", busy0, 1'b1);
    chk("comp_wrdy", w_rdy0, 1'b0);
    chk("comp_ardy", a_rdy0, 1'b1);
    act_valid_in = 1'b1; act_in = pk16(5, 6);
    tick();
    act_valid_in = 1'b0; act_in = '0;
    repeat (3) tick();
    chk("lat_early", ov0, 1'b0);
    tick();
    chk("lat_ov", ov0, 1'b1);
    chk("mac_data", od0, pk32(23, 34));
    chk("mac_sat_data", od1, pk32(23, 34));
    tick();
    chk("single_done", ov0, 1'b0);

    // last accept together with flush, with bias
    act_valid_in = 1'b1; act_in = pk16(1, -1);
    bias_in = pk32(100, -7); flush_in = 1'b1;
    tick();
    flush_in = 1'b0; bias_in = '0; act_in = pk16(9, 9);
    chk("drain_ardy", a_rdy0, 1'b0);
    repeat (3) tick();
    act_valid_in = 1'b0; act_in = '0;
    tick();
    chk("flush_ov", ov0, 1'b1);
    chk("flush_data", od0, pk32(98, -9));
    chk("flush_busy", busy0, 1'b1);
    tick();
    chk("flush_noextra", ov0, 1'b0);
    wait_idle("flush_idle");

    // identity, 8 back-to-back vectors
    load_w(pk16(1, 0), pk16(0, 1));
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        act_valid_in = 1'b1;
        act_in  = pk16(k + 1, -3 * (k + 1));
        bias_in = pk32(1000, 0);
      end else begin
        act_valid_in = 1'b0; act_in = '0; bias_in = '0;
      end
      tick();
      if (k >= 4) begin
        chk("stream_ov", ov0, 1'b1);
        chk("stream_data", od0, pk32(k - 3 + 1000, -3 * (k - 3)));
      end else begin
        chk("stream_lat", ov0, 1'b0);
      end
    end
    tick();
    chk("stream_end", ov0, 1'b0);

    // backpressure: out_ready low 5 cycles while results are pending
    sent = 0; rcvd = 0; nstall = 0; prev = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 11);
      if (sent < 8) begin
        act_valid_in = 1'b1;
        act_in  = pk16(2 * sent, sent - 5);
        bias_in = pk32(sent, 7 * sent);
      end else begin
        act_valid_in = 1'b0; act_in = '0; bias_in = '0;
      end
      #1;
      if (ov0 && !out_ready) begin
        nstall++;
        chk("bp_ardy", a_rdy0, 1'b0);
        if (prev) chk("bp_hold", od0, held);
        held = od0;
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
      if (ov0 && out_ready) begin
        chk("bp_data", od0, pk32(3 * rcvd, 8 * rcvd - 5));
        rcvd++;
      end
      acc = act_valid_in && a_rdy0;
      tick();
      if (acc) sent++;
    end
    act_valid_in = 1'b0; act_in = '0; bias_in = '0; out_ready = 1'b1;
    chk("bp_sent", sent, 8);
    chk("bp_rcvd", rcvd, 8);
    chk("bp_stalls", nstall, 5);
    tick();
    chk("bp_noextra", ov0, 1'b0);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    wait_idle("bp_idle");

    // extreme operands: wrap vs clamp
    load_w(pk16(-32768, -32768), pk16(-32768, -32768));
    act_valid_in = 1'b1; act_in = pk16(-32768, -32768);
    tick();
    act_valid_in = 1'b0; act_in = '0;
    repeat (4) tick();
    chk("ext_ov", ov0, 1'b1);
    chk("ext_wrap", od0, {2{32'h8000_0000}});
    chk("ext_sat", od1, {2{32'h7FFF_FFFF}});
    tick();

    // reset with three vectors in flight
    act_valid_in = 1'b1; act_in = pk16(3, 4); bias_in = pk32(1, 1);
    repeat (3) tick();
    act_valid_in = 1'b0; act_in = '0; bias_in = '0;
    rst_n = 1'b0;
    tick();
    chk("mrst_ov", ov0, 1'b0);
    chk("mrst_od", od0, 64'd0);
    chk("mrst_busy", busy0, 1'b0);
    chk("mrst_ardy", a_rdy0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mrst_quiet", ov0, 1'b0);
    end
    chk("mrst_idle", busy0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
